// File: rtl/alarm_pkg.sv
// Shared types and BCD helpers for the alarm unit.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

    localparam logic [7:0] HH_MIN = 8'h01;
    localparam logic [7:0] HH_MAX = 8'h12;
    localparam logic [7:0] MM_MAX = 8'h59;

    // Both low nibbles must be decimal digits; the range compares then
    // bound the high nibbles, so plain BCD magnitude compares are enough.
    function automatic logic bcd_time_ok(input logic [7:0] hh, input logic [7:0] mm);
        return (hh[3:0] <= 4'd9) && (mm[3:0] <= 4'd9) &&
               (hh >= HH_MIN) && (hh <= HH_MAX) && (mm <= MM_MAX);
    endfunction

endpackage

// File: rtl/alarm_tick_timer.sv
// Loadable down-counter clocked by the one-second tick; flags the tick that
// takes it from 1 to 0. Loading 0 parks it.
module alarm_tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         ena,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over counting; an idle counter rests at zero.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (ena && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    // Independent of load so the controller's next-state logic stays loop-free.
    assign zero = ena && (cnt == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: programmable alarm time, match detect, ring with
// auto-timeout, bounded snooze.
//
//  state   | meaning
//  IDLE    | alarm disabled, matches ignored
//  ARMED   | waiting for the alarm minute
//  RINGING | buzzer on, ring timer running
//  SNOOZE  | buzzer off, snooze timer running
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ena,
    input  logic                            pm,
    input  logic [7:0]                      hh,
    input  logic [7:0]                      mm,
    input  logic [7:0]                      ss,
    input  logic                            set_valid,
    input  logic                            set_pm,
    input  logic [7:0]                      set_hh,
    input  logic [7:0]                      set_mm,
    input  logic                            arm,
    input  logic                            disarm,
    input  logic                            snooze,
    output logic                            ring,
    output logic                            armed,
    output logic [1:0]                      state,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snoozes_used,
    output logic                            set_err
);

    localparam int TMAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = $clog2(MAX_SNOOZE + 1);

    state_t          st, st_nxt;
    logic [SW-1:0]   used_nxt;
    logic            alm_pm;
    logic [7:0]      alm_hh, alm_mm;
    logic            match;
    logic            tmr_load, tmr_zero;
    logic [TW-1:0]   tmr_val;

    assign match = ena && (pm == alm_pm) && (hh == alm_hh) && (mm == alm_mm) && (ss == 8'h00);

    alarm_tick_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_val),
        .ena   (ena),
        .zero  (tmr_zero)
    );

    // Next state, snooze count and timer load; disarm overrides everything.
    always_comb begin
        st_nxt   = st;
        used_nxt = snoozes_used;
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (disarm) begin
            st_nxt   = IDLE;
            used_nxt = '0;
            tmr_load = 1'b1;
        end else begin
            case (st)
                IDLE: begin
                    if (arm) st_nxt = ARMED;
                end
                ARMED: begin
                    if (match) begin
                        st_nxt   = RINGING;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(RING_SECS);
                    end
                end
                RINGING: begin
                    if (snooze && (snoozes_used < SW'(MAX_SNOOZE))) begin
                        st_nxt   = SNOOZE;
                        used_nxt = snoozes_used + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SNOOZE_SECS);
                    end else if (tmr_zero) begin
                        st_nxt   = ARMED;
                        used_nxt = '0;
                    end
                end
                SNOOZE: begin
                    if (tmr_zero) begin
                        st_nxt   = RINGING;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(RING_SECS);
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    // State, status outputs and the alarm time register.
    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= IDLE;
            snoozes_used <= '0;
            ring         <= 1'b0;
            set_err      <= 1'b0;
            alm_pm       <= 1'b0;
            alm_hh       <= 8'h12;
            alm_mm       <= 8'h00;
        end else begin
            st           <= st_nxt;
            snoozes_used <= used_nxt;
            ring         <= (st_nxt == RINGING);
            set_err      <= set_valid && !bcd_time_ok(set_hh, set_mm);
            if (set_valid && bcd_time_ok(set_hh, set_mm)) begin
                alm_pm <= set_pm;
                alm_hh <= set_hh;
                alm_mm <= set_mm;
            end
        end
    end

    assign state = st;
    assign armed = (st != IDLE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl with a cycle-level reference model.
module tb_alarm_ctrl;

    localparam int RING = 5;
    localparam int SNZ  = 7;
    localparam int MAXS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1, ena = 1'b0, pm = 1'b0;
    logic [7:0] hh = 8'h12, mm = 8'h00, ss = 8'h00;
    logic       set_valid = 1'b0, set_pm = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00;
    logic       arm = 1'b0, disarm = 1'b0, snooze = 1'b0;
    logic       ring, armed, set_err;
    logic [1:0] state;
    logic [1:0] snoozes_used;

    int n_pass = 0, n_total = 0;
    bit chk_en = 1'b0;

    alarm_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
        .clk(clk), .reset(reset), .ena(ena), .pm(pm), .hh(hh), .mm(mm), .ss(ss),
        .set_valid(set_valid), .set_pm(set_pm), .set_hh(set_hh), .set_mm(set_mm),
        .arm(arm), .disarm(disarm), .snooze(snooze),
        .ring(ring), .armed(armed), .state(state), .snoozes_used(snoozes_used),
        .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: 0 idle, 1 armed, 2 ringing, 3 snoozing; m_left is
    // the number of ena ticks still owed in the current ring/snooze phase.
    int m_st, m_left, m_used, a_h, a_m;
    bit m_err, a_pm, m_match, m_ok;

    function automatic int bcd2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit digits_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_st = 0; m_left = 0; m_used = 0; m_err = 0;
            a_pm = 0; a_h = 12; a_m = 0;
        end else begin
            m_match = ena && (pm == a_pm) && (bcd2i(hh) == a_h) && (bcd2i(mm) == a_m) && (ss == 8'h00);
            m_ok = digits_ok(set_hh) && digits_ok(set_mm) &&
                   bcd2i(set_hh) >= 1 && bcd2i(set_hh) <= 12 && bcd2i(set_mm) <= 59;
            m_err = set_valid && !m_ok;
            if (set_valid && m_ok) begin
                a_pm = set_pm; a_h = bcd2i(set_hh); a_m = bcd2i(set_mm);
            end
            if (disarm) begin
                m_st = 0; m_used = 0; m_left = 0;
            end else if (m_st == 0) begin
                if (arm) m_st = 1;
            end else if (m_st == 1) begin
                if (m_match) begin m_st = 2; m_left = RING; end
            end else if (m_st == 2) begin
                if (snooze && m_used < MAXS) begin
                    m_st = 3; m_used++; m_left = SNZ;
                end else if (ena) begin
                    m_left--;
                    if (m_left == 0) begin m_st = 1; m_used = 0; end
                end
            end else begin
                if (ena) begin
                    m_left--;
                    if (m_left == 0) begin m_st = 2; m_left = RING; end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("state", int'(state), m_st);
            check("ring", int'(ring), int'(m_st == 2));
            check("armed", int'(armed), int'(m_st != 0));
            check("snoozes_used", int'(snoozes_used), m_used);
            check("set_err", int'(set_err), int'(m_err));
        end
    end

    task automatic cyc();
        @(negedge clk);
        ena = 0; arm = 0; disarm = 0; snooze = 0; set_valid = 0;
    endtask

    task automatic tick(input logic p, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        pm = p; hh = h; mm = m; ss = s; ena = 1; cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ss = 8'h17; ena = 1; cyc();
        end
    endtask

    task automatic do_set(input logic p, input logic [7:0] h, input logic [7:0] m);
        set_valid = 1; set_pm = p; set_hh = h; set_mm = m; cyc();
    endtask

    logic [7:0] bad_hh [4] = '{8'h13, 8'h00, 8'h07, 8'h0A};
    logic [7:0] bad_mm [4] = '{8'h30, 8'h30, 8'h5A, 8'h00};

    initial begin
        reset = 1; cyc(); chk_en = 1; cyc(); reset = 0;
        check("reset_state", int'(state), 0);
        check("reset_ring", int'(ring), 0);

        do_set(0, 8'h07, 8'h30);
        check("set_ok", int'(set_err), 0);
        arm = 1; cyc();
        check("arm", int'(state), 1);
        tick(0, 8'h07, 8'h29, 8'h59);
        check("no_early_match", int'(state), 1);
        tick(0, 8'h07, 8'h30, 8'h00);
        check("match_ring", int'(ring), 1);
        ticks(RING - 1);
        check("ring_before_timeout", int'(ring), 1);
        ticks(1);
        check("timeout_armed", int'(state), 1);
        tick(1, 8'h07, 8'h30, 8'h00);
        check("pm_no_ring", int'(ring), 0);
        tick(0, 8'h07, 8'h30, 8'h00);
        check("next_day_ring", int'(state), 2);

        for (int k = 1; k <= MAXS; k++) begin
            snooze = 1; cyc();
            check("snooze_state", int'(state), 3);
            check("snooze_count", int'(snoozes_used), k);
            ticks(SNZ - 1);
            check("snooze_hold", int'(ring), 0);
            ticks(1);
            check("snooze_rering", int'(ring), 1);
        end
        snooze = 1; cyc();
        check("snooze_limit_state", int'(state), 2);
        check("snooze_limit_count", int'(snoozes_used), MAXS);
        repeat (100) cyc();
        check("ena_freeze", int'(ring), 1);
        ticks(RING);
        check("limit_timeout", int'(state), 1);
        check("limit_timeout_used", int'(snoozes_used), 0);

        tick(0, 8'h07, 8'h30, 8'h00);
        ticks(RING - 1);
        snooze = 1; ticks(1);
        check("snooze_beats_timeout", int'(state), 3);
        ticks(SNZ);
        disarm = 1; snooze = 1; cyc();
        check("disarm_beats_snooze", int'(state), 0);
        check("disarm_used", int'(snoozes_used), 0);
        tick(0, 8'h07, 8'h30, 8'h00);
        check("idle_ignores_match", int'(state), 0);

        for (int i = 0; i < 4; i++) begin
            do_set(0, bad_hh[i], bad_mm[i]);
            check("set_err_pulse", int'(set_err), 1);
            cyc();
            check("set_err_clear", int'(set_err), 0);
        end
        arm = 1; cyc();
        tick(0, 8'h07, 8'h30, 8'h00);
        check("alarm_reg_kept", int'(state), 2);
        do_set(1, 8'h12, 8'h59);
        check("set_1259pm_ok", int'(set_err), 0);
        check("set_keeps_ring", int'(ring), 1);
        ticks(RING);
        tick(1, 8'h12, 8'h59, 8'h00);
        check("match_1259pm", int'(state), 2);

        snooze = 1; cyc();
        reset = 1; cyc(); reset = 0;
        check("reset_mid_snooze", int'(state), 0);
        arm = 1; cyc();
        tick(0, 8'h12, 8'h00, 8'h00);
        check("reset_alarm_reg", int'(ring), 1);
        reset = 1; cyc(); reset = 0;
        check("reset_mid_ring_state", int'(state), 0);
        check("reset_mid_ring_ring", int'(ring), 0);
        arm = 1; cyc();
        tick(0, 8'h12, 8'h00, 8'h00);
        ticks(RING - 1);
        check("timer_fresh_after_reset", int'(ring), 1);
        ticks(1);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
